allpass_coef_ctrl: RTL and testbench

ALLPASS_COEF_CTRL -- requirements
Module: allpass_coef_ctrl

---
 rtl/allpass_coef_ctrl.sv | 96 +++++++++
 tb/tb_allpass_coef_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/allpass_coef_ctrl.sv
// allpass_coef_ctrl: loads a shadow coefficient set, swaps it onto c at a frame strobe, then holds the filter in reset for a flush.
module allpass_coef_ctrl #(
  parameter int WIDTH     = 16,
  parameter int N         = 5,
  parameter int FLUSH_LEN = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [WIDTH-1:0]   cfg_data,
  input  logic               cfg_last,
  input  logic               cfg_abort,
  input  logic               sync_stb,
  output logic [WIDTH*N-1:0] c,
  output logic               filt_rst,
  output logic               busy,
  output logic               swap_done,
  output logic               cfg_err
);
  localparam int IW = $clog2(N);
  localparam int CW = FLUSH_LEN > 1 ? $clog2(FLUSH_LEN) : 1;
  typedef enum logic [1:0] {IDLE, LOAD, PEND, FLUSH} state_t;
  state_t                     state_q, state_d;
  logic [IW-1:0]              idx_q, idx_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic [N-1:0][WIDTH-1:0]    shadow_q, shadow_d, c_q, c_d;
  logic                       filt_rst_q, filt_rst_d, busy_q, busy_d;
  logic                       swap_done_q, swap_done_d, cfg_err_q, cfg_err_d;
  logic                       acc, abort, last_idx, bad, store, swap;
  assign cfg_ready = state_q == IDLE || state_q == LOAD;
  assign acc       = cfg_valid & cfg_ready;
  assign abort     = cfg_abort & (state_q == LOAD || state_q == PEND);
  assign last_idx  = idx_q == IW'(N - 1);
  // cfg_last must coincide exactly with the final index; anything else is a framing error
  assign bad       = acc & ~abort & (cfg_last != last_idx);
  assign store     = acc & ~abort & ~bad;
  assign swap      = state_q == PEND & sync_stb & ~cfg_abort;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FLUSH;
      idx_q       <= '0;
      cnt_q       <= CW'(FLUSH_LEN - 1);
      shadow_q    <= '0;
      c_q         <= '0;
      filt_rst_q  <= 1'b1;
      busy_q      <= 1'b1;
      swap_done_q <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      shadow_q    <= shadow_d;
      c_q         <= c_d;
      filt_rst_q  <= filt_rst_d;
      busy_q      <= busy_d;
      swap_done_q <= swap_done_d;
      cfg_err_q   <= cfg_err_d;
    end
  end
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    c_d      = c_q;
    if (abort | bad) begin
      state_d  = IDLE;
      idx_d    = '0;
      shadow_d = '0;
    end else if (store) begin
      shadow_d[idx_q] = cfg_data;
      idx_d   = last_idx ? '0 : idx_q + 1'b1;
      state_d = last_idx ? PEND : LOAD;
    end else if (swap) begin
      c_d     = shadow_q;
      cnt_d   = CW'(FLUSH_LEN - 1);
      state_d = FLUSH;
    end else if (state_q == FLUSH) begin
      cnt_d   = cnt_q - 1'b1;
      state_d = cnt_q == '0 ? IDLE : FLUSH;
    end
  end
  always_comb begin
    filt_rst_d  = state_d == FLUSH;
    busy_d      = state_d != IDLE;
    swap_done_d = swap;
    cfg_err_d   = bad;
  end
  assign c         = c_q;
  assign filt_rst  = filt_rst_q;
  assign busy      = busy_q;
  assign swap_done = swap_done_q;
  assign cfg_err   = cfg_err_q;
endmodule

// File: tb/tb_allpass_coef_ctrl.sv
// tb_allpass_coef_ctrl: directed table, corner sequences and random traffic checked against a queue-based model.
module tb_allpass_coef_ctrl;
  localparam int W  = 16;
  localparam int N  = 5;
  localparam int FL = 8;
  logic clk = 0, rst_n = 1;
  logic cfg_valid = 0, cfg_last = 0, cfg_abort = 0, sync_stb = 0;
  logic [W-1:0] cfg_data = '0;
  logic cfg_ready, filt_rst, busy, swap_done, cfg_err;
  logic [W*N-1:0] c;
  int n_tests = 0, n_fail = 0;
  allpass_coef_ctrl #(.WIDTH(W), .N(N), .FLUSH_LEN(FL)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_data(cfg_data), .cfg_last(cfg_last), .cfg_abort(cfg_abort),
    .sync_stb(sync_stb), .c(c), .filt_rst(filt_rst), .busy(busy),
    .swap_done(swap_done), .cfg_err(cfg_err));
  always #5 clk = ~clk;
  logic [W-1:0] m_c [N];
  logic [W-1:0] m_q [$];
  bit m_pend, m_swap, m_err;
  int m_fl;
  task automatic m_reset();
    for (int k = 0; k < N; k++) m_c[k] = '0;
    m_q.delete();
    m_pend = 0;
    m_fl = FL;
    m_swap = 0;
    m_err = 0;
  endtask
  task automatic m_step(input bit v, input logic [W-1:0] d, input bit l, a, s);
    m_swap = 0;
    m_err = 0;
    if (m_fl > 0) m_fl--;
    else if (a && (m_pend || m_q.size() > 0)) begin
      m_q.delete();
      m_pend = 0;
    end else if (m_pend) begin
      if (s) begin
        for (int k = 0; k < N; k++) m_c[k] = m_q[k];
        m_q.delete();
        m_pend = 0;
        m_swap = 1;
        m_fl = FL;
      end
    end else if (v) begin
      m_q.push_back(d);
      if (l && m_q.size() == N) m_pend = 1;
      else if (l || m_q.size() == N) begin
        m_err = 1;
        m_q.delete();
      end
    end
  endtask
  function automatic logic [W*N-1:0] m_cv();
    logic [W*N-1:0] r;
    for (int k = 0; k < N; k++) r[k*W +: W] = m_c[k];
    return r;
  endfunction
  task automatic chk(input string nm, input logic [W*N-1:0] act, input logic [W*N-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic cyc(input bit v, input logic [W-1:0] d, input bit l, a, s);
    cfg_valid = v;
    cfg_data = d;
    cfg_last = l;
    cfg_abort = a;
    sync_stb = s;
    chk("ready", cfg_ready, !(m_pend || m_fl > 0));
    @(posedge clk);
    m_step(v, d, l, a, s);
    #1;
    chk("c", c, m_cv());
    chk("filt_rst", filt_rst, m_fl > 0);
    chk("busy", busy, m_fl > 0 || m_pend || m_q.size() > 0);
    chk("swap_done", swap_done, m_swap);
    chk("cfg_err", cfg_err, m_err);
  endtask
  task automatic rst_seq();
    {cfg_valid, cfg_last, cfg_abort, sync_stb} = '0;
    rst_n = 0;
    m_reset();
    #1;
    chk("rst_c", c, '0);
    chk("rst_filt", filt_rst, 1);
    chk("rst_busy", busy, 1);
    chk("rst_ready", cfg_ready, 0);
    chk("rst_swap", swap_done, 0);
    chk("rst_err", cfg_err, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
  endtask
  task automatic flush_len(input string nm);
    int n = 0;
    do begin
      cyc(0, '0, 0, 0, 0);
      n++;
    end while (filt_rst && n < 100);
    chk(nm, n, FL);
  endtask
  task automatic ld(input int n, input bit s_last);
    for (int i = 0; i < n; i++) cyc(1, W'((i + 1) * 'h1100), i == n - 1, 0, s_last && i == n - 1);
  endtask
  typedef struct {
    bit v; logic [W-1:0] d; bit l, a, s;
    bit e_swap, e_err, e_busy, e_filt;
  } vec_t;
  vec_t tv [12];
  initial begin
    tv = '{
      '{1, 16'h1000, 0, 0, 0, 0, 0, 1, 0},
      '{1, 16'h2000, 0, 0, 0, 0, 0, 1, 0},
      '{1, 16'h3000, 1, 0, 0, 0, 1, 0, 0},
      '{1, 16'h1000, 0, 0, 0, 0, 0, 1, 0},
      '{1, 16'h2000, 0, 0, 0, 0, 0, 1, 0},
      '{1, 16'h3000, 0, 0, 0, 0, 0, 1, 0},
      '{1, 16'h4000, 0, 0, 0, 0, 0, 1, 0},
      '{1, 16'h5000, 1, 0, 0, 0, 0, 1, 0},
      '{1, 16'hdead, 1, 0, 0, 0, 0, 1, 0},
      '{0, 16'h0000, 0, 0, 0, 0, 0, 1, 0},
      '{0, 16'h0000, 0, 0, 0, 0, 0, 1, 0},
      '{0, 16'h0000, 0, 0, 1, 1, 0, 1, 1}};
    #2;
    rst_seq();
    flush_len("reset_flush_len");
    chk("idle_ready", cfg_ready, 1);
    chk("idle_c", c, '0);
    for (int i = 0; i < 12; i++) begin
      cyc(tv[i].v, tv[i].d, tv[i].l, tv[i].a, tv[i].s);
      chk($sformatf("tv%0d_swap", i), swap_done, tv[i].e_swap);
      chk($sformatf("tv%0d_err", i), cfg_err, tv[i].e_err);
      chk($sformatf("tv%0d_busy", i), busy, tv[i].e_busy);
      chk($sformatf("tv%0d_filt", i), filt_rst, tv[i].e_filt);
    end
    chk("c_swap", c, 80'h5000_4000_3000_2000_1000);
    flush_len("swap_flush_len");
    ld(5, 0);
    cyc(0, '0, 0, 1, 1);
    chk("abort_noswap", swap_done, 0);
    chk("abort_idle", busy, 0);
    chk("abort_c", c, 80'h5000_4000_3000_2000_1000);
    ld(5, 1);
    chk("coinc_noswap", swap_done, 0);
    cyc(0, '0, 0, 0, 0);
    cyc(0, '0, 0, 0, 1);
    chk("second_swap", swap_done, 1);
    chk("second_c", c, 80'h5500_4400_3300_2200_1100);
    flush_len("second_flush_len");
    ld(2, 0);
    rst_seq();
    flush_len("rerst_flush_len");
    for (int i = 0; i < 3000; i++) begin
      bit v, l, a, s;
      v = $urandom_range(0, 9) < 6;
      l = (m_q.size() == N - 1) ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 19) == 0);
      a = $urandom_range(0, 29) == 0;
      s = $urandom_range(0, 4) == 0;
      cyc(v, W'($urandom), l, a, s);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
